// File: rtl/tdm_pkg.sv
// Shared definitions for the TDM link (transmitter and receiver).
// Holds the default geometry, the slot-index width and the FSM state encoding.
package tdm_pkg;

    localparam int CH_DEF       = 4;
    localparam int W_DEF        = 8;
    localparam int SLOT_CYC_DEF = 1;
    localparam int SEL_W        = $clog2(CH_DEF);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } tdm_state_e;

    // A counter over n values needs at least one bit, even when n is 1.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tdm_mux_tx_if.sv
// Frame-in / slot-out bundle of the TDM transmitter.
// The master side supplies frames and watches the line; the slave side is the transmitter.
interface tdm_mux_tx_if #(
    parameter int CH = tdm_pkg::CH_DEF,
    parameter int W  = tdm_pkg::W_DEF
) ();

    localparam int SEL_W = $clog2(CH);

    logic              in_valid;
    logic              in_ready;
    logic [CH*W-1:0]   in_data;
    logic [W-1:0]      tx_data;
    logic [SEL_W-1:0]  tx_sel;
    logic              tx_valid;
    logic              tx_sync;

    modport master (
        output in_valid, in_data,
        input  in_ready, tx_data, tx_sel, tx_valid, tx_sync
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, tx_data, tx_sel, tx_valid, tx_sync
    );

endinterface

// File: rtl/tdm_slot_counter.sv
// Hold and slot counters for the TDM transmitter.
// The hold counter paces each slot; the slot counter steps when its owner says so.
module tdm_slot_counter
    import tdm_pkg::*;
#(
    parameter int CH       = CH_DEF,
    parameter int SLOT_CYC = SLOT_CYC_DEF,
    parameter int SEL_W    = $clog2(CH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             hold_adv_i,
    input  logic             slot_adv_i,
    output logic [SEL_W-1:0] slot_next_o,
    output logic             slot_last_o,
    output logic             frame_last_o
);

    localparam int               HOLD_W    = cnt_width(SLOT_CYC);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(SLOT_CYC - 1);
    localparam logic [SEL_W-1:0]  SLOT_LAST = SEL_W'(CH - 1);

    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [SEL_W-1:0]  slot_q, slot_d;

    assign slot_last_o  = (hold_q == HOLD_LAST);
    assign frame_last_o = slot_last_o && (slot_q == SLOT_LAST);
    assign slot_next_o  = slot_d;

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
        hold_d = hold_q;
        slot_d = slot_q;
        if (load_i) begin
            hold_d = '0;
            slot_d = '0;
        end else begin
            if (hold_adv_i) hold_d = slot_last_o ? '0 : hold_q + HOLD_W'(1);
            if (slot_adv_i) slot_d = slot_q + SEL_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q <= '0;
            slot_q <= '0;
        end else begin
            hold_q <= hold_d;
            slot_q <= slot_d;
        end
    end

endmodule

// File: rtl/tdm_mux_tx.sv
// TDM transmitter: takes one CH-word frame per handshake and sends it one slot at a time.
// Outputs are registered from next-state values so they line up with the internal state.
module tdm_mux_tx
    import tdm_pkg::*;
#(
    parameter int CH       = CH_DEF,
    parameter int W        = W_DEF,
    parameter int SLOT_CYC = SLOT_CYC_DEF
) (
    input  logic       clk,
    input  logic       rst,
    tdm_mux_tx_if.slave bus
);

    localparam int SEL_W = $clog2(CH);

    tdm_state_e       state_q, state_d;
    logic             load, hold_adv, slot_adv;
    logic             slot_last, frame_last;
    logic [SEL_W-1:0] slot_d;
    logic             in_ready, handshake;

    logic [CH*W-1:0]  buf_q;
    logic [CH*W-1:0]  src;
    logic [W-1:0]     words [CH];

    logic             send_d;
    logic [W-1:0]     tx_data_q, tx_data_d;
    logic [SEL_W-1:0] tx_sel_q, tx_sel_d;
    logic             tx_valid_q, tx_sync_q, tx_sync_d;

    tdm_slot_counter #(
        .CH       (CH),
        .SLOT_CYC (SLOT_CYC),
        .SEL_W    (SEL_W)
    ) u_cnt (
        .clk          (clk),
        .rst          (rst),
        .load_i       (load),
        .hold_adv_i   (hold_adv),
        .slot_adv_i   (slot_adv),
        .slot_next_o  (slot_d),
        .slot_last_o  (slot_last),
        .frame_last_o (frame_last)
    );

    // Ready depends only on state and counters; in_valid never feeds back into it.
    assign in_ready  = !rst && ((state_q == ST_IDLE) || frame_last);
    assign handshake = bus.in_valid && in_ready;

    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        hold_adv = 1'b0;
        slot_adv = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (handshake) begin
                    load    = 1'b1;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (frame_last) begin
                    if (handshake) load    = 1'b1;
                    else           state_d = ST_IDLE;
                end else begin
                    hold_adv = 1'b1;
                    slot_adv = slot_last;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A freshly accepted frame is sent straight from in_data, since the buffer loads on the same edge.
    always_comb begin
        src = load ? bus.in_data : buf_q;
        for (int i = 0; i < CH; i++) words[i] = src[i*W +: W];
        send_d    = (state_d == ST_SEND);
        tx_sel_d  = send_d ? slot_d : '0;
        tx_data_d = send_d ? words[slot_d] : '0;
        tx_sync_d = send_d && (slot_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            tx_data_q  <= '0;
            tx_sel_q   <= '0;
            tx_valid_q <= 1'b0;
            tx_sync_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_data_q  <= tx_data_d;
            tx_sel_q   <= tx_sel_d;
            tx_valid_q <= send_d;
            tx_sync_q  <= tx_sync_d;
        end
    end

    // NOTE: the frame buffer has no reset; it is only ever read after a load, so clearing it buys nothing.
    always_ff @(posedge clk) begin
        if (load) buf_q <= bus.in_data;
    end

    assign bus.in_ready = in_ready;
    assign bus.tx_data  = tx_data_q;
    assign bus.tx_sel   = tx_sel_q;
    assign bus.tx_valid = tx_valid_q;
    assign bus.tx_sync  = tx_sync_q;

endmodule
